wavuno_stereo_dac: RTL and testbench
====================================

WAVUNO_STEREO_DAC -- requirements
Module: wavuno_stereo_dac

Interface
REQ-001 SHALL have parameter NCH, default 4, number of PCM channels (1..8).
REQ-002 SHALL have parameter SW, default 8, sample width in bits; D = SW+4 is the mix width and S = D+clog2(NCH) is the sum width.
REQ-003 SHALL have port clk28  in  1  system clock, 28 MHz; all logic on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sample_strobe  in  1  one-cycle pulse that starts a mixing frame.
REQ-006 SHALL have port ch_sample  in  NCH*SW  unsigned samples; channel k is in bits [k*SW +: SW].
REQ-007 SHALL have port ch_vol  in  NCH*4  per-channel volume, 0 to 15.
REQ-008 SHALL have port ch_pan  in  NCH*2  per-channel pan: bit0 routes to left, bit1 routes to right; 00 mutes the channel.
REQ-009 SHALL have port audio_out_left  out  1  left 1-bit sigma-delta output.
REQ-010 SHALL have port audio_out_right  out  1  right 1-bit sigma-delta output.
REQ-011 SHALL have port mix_busy  out  1  high while a frame is being mixed.
REQ-012 SHALL have port clip  out  1  one-cycle pulse when either side saturates.
REQ-013 SHALL have port overrun  out  1  one-cycle pulse when sample_strobe arrives while mix_busy is high.

Function
REQ-014 SHALL implement an FSM with states IDLE, MIX and LOAD.
REQ-015 IDLE with sample_strobe high: SHALL snapshot ch_sample, ch_vol and ch_pan, clear accL/accR (S bits), set the channel index to 0, and go to MIX.
REQ-016 MIX: SHALL handle one channel per cycle; prod = sample*vol (D bits); prod is added to accL if pan bit0 is set and to accR if pan bit1 is set; after channel NCH-1 the FSM goes to LOAD.
REQ-017 LOAD: mixL <= min(accL, 2^D-1) and mixR likewise; clip SHALL pulse if either side exceeded 2^D-1; then the FSM returns to IDLE.
REQ-018 Latency SHALL be NCH+2 cycles from the strobe edge until the new mixL/mixR values are visible.
REQ-019 mix_busy SHALL be high in MIX and LOAD.
REQ-020 A strobe in MIX or LOAD SHALL be ignored and SHALL pulse overrun; the frame in progress is unaffected.
REQ-021 Inputs changing during MIX SHALL NOT affect the frame in progress, because only the snapshot is used.
REQ-022 Per side, every cycle: sd <= sd[D-1:0] + mix, with sd D+1 bits wide; the output SHALL be a register of sd[D].
REQ-023 The density of ones SHALL be exactly mix/2^D over any 2^D-cycle window after a settled load; mix=0 gives constant 0.
REQ-024 Because mix is held at most 2^D-1, the output SHALL never be stuck at 1 for the whole period.

Reset
REQ-025 While rst_n is low: FSM in IDLE, accumulators, mixL/mixR and sd all 0, every output 0.
REQ-026 Reset asserted mid-MIX SHALL abort the frame; after release the block waits for a fresh strobe.
REQ-027 No output SHALL change in the first cycle after release unless a strobe is present.

Configuration
REQ-028 The feature macro SHALL be WAVUNO_DAC_DITHER_EN.
REQ-029 With the macro defined: a 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle, and its bit 0 is added into the sd LSB carry-in on both sides, except when mix is 2^D-1.
REQ-030 Without the macro: no LFSR is present, and the behaviour is exactly REQ-022 and REQ-023.

Structure
REQ-031 Package wavuno_pkg SHALL hold the FSM state typedef, the pan encodings, the LFSR seed and the LFSR taps.
REQ-032 Sub-module wavuno_sd_mod (parameter D) SHALL implement one sigma-delta side and SHALL be instantiated twice.

Verification (NCH=4, SW=8, D=12)
REQ-033 Reset check: hold rst_n low -> all outputs 0 and mix_busy 0; release -> outputs stay 0.
REQ-034 Mono centre: ch0 = 8'h80, vol 15, pan 11, others muted; strobe -> mixL = mixR = 12'h780 after 6 cycles; exactly 1920 ones per 4096-cycle window on each side (dither off).
REQ-035 Pan left: ch1 = 8'hFF, vol 15, pan 01 -> mixL = 12'hEF1 and mixR = 0; audio_out_right stays 0.
REQ-036 Saturation: all channels 8'hFF, vol 15, pan 11 (sum 15300) -> mixL = mixR = 12'hFFF, clip pulses exactly one cycle, and the output has exactly one zero per 4096 cycles.
REQ-037 Overrun: a second strobe 2 cycles after the first -> overrun pulses once, the first frame completes normally, and there is no restart.
REQ-038 Reset mid-MIX: assert rst_n on MIX cycle 2 -> after release the state is IDLE, mix values are 0, and the next strobe mixes correctly.

Source files
------------

// File: rtl/wavuno_pkg.sv
// Shared types and constants for the wavuno stereo DAC.
// Optional dither build: define WAVUNO_DAC_DITHER_EN.
package wavuno_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        LOAD = 2'd2
    } mix_state_t;

    localparam logic [1:0] PAN_MUTE  = 2'b00;
    localparam logic [1:0] PAN_LEFT  = 2'b01;
    localparam logic [1:0] PAN_RIGHT = 2'b10;
    localparam logic [1:0] PAN_BOTH  = 2'b11;
    localparam int PAN_L_BIT = 0;
    localparam int PAN_R_BIT = 1;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of taps 16,14,13,11
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(
        input logic [15:0] s
    );
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/wavuno_sd_mod.sv
// First-order 1-bit sigma-delta modulator for one stereo side.
// The carry out of a D-bit phase accumulator is the pulse stream.
module wavuno_sd_mod #(
    parameter int D = 12
) (
    input  logic         clk28,
    input  logic         rst_n,
    input  logic [D-1:0] mix,
    input  logic         dither,
    output logic         sd_out
);

    logic [D:0] sd;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sd     <= '0;
            sd_out <= 1'b0;
        end else begin
            sd     <= {1'b0, sd[D-1:0]} + {1'b0, mix}
                    + (D+1)'(dither);
            sd_out <= sd[D];
        end
    end

endmodule

// File: rtl/wavuno_stereo_dac.sv
// Multi-channel PCM mixer feeding two 1-bit sigma-delta outputs.
// Optional LFSR dither build: define WAVUNO_DAC_DITHER_EN.
module wavuno_stereo_dac #(
    parameter int NCH = 4,
    parameter int SW  = 8
) (
    input  logic            clk28,
    input  logic            rst_n,
    input  logic            sample_strobe,
    input  logic [NCH*SW-1:0] ch_sample,
    input  logic [NCH*4-1:0]  ch_vol,
    input  logic [NCH*2-1:0]  ch_pan,
    output logic            audio_out_left,
    output logic            audio_out_right,
    output logic            mix_busy,
    output logic            clip,
    output logic            overrun
);

    import wavuno_pkg::*;

    localparam int D  = SW + 4;
    localparam int S  = D + $clog2(NCH);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [D-1:0]  MAXV = {D{1'b1}};
    localparam logic [IW-1:0] LAST = IW'(NCH - 1);

    mix_state_t state;
    logic [IW-1:0]     idx;
    logic [NCH*SW-1:0] snap_s;
    logic [NCH*4-1:0]  snap_v;
    logic [NCH*2-1:0]  snap_p;
    logic [S-1:0]      acc_l;
    logic [S-1:0]      acc_r;
    logic [D-1:0]      mix_l;
    logic [D-1:0]      mix_r;

    logic [SW-1:0] cur_s;
    logic [3:0]    cur_v;
    logic [1:0]    cur_p;
    logic [D-1:0]  prod;
    logic          over_l;
    logic          over_r;

    always_comb begin
        cur_s  = snap_s[idx*SW +: SW];
        cur_v  = snap_v[idx*4 +: 4];
        cur_p  = snap_p[idx*2 +: 2];
        // SW x 4 bits always fits in D = SW+4 bits
        prod   = D'(cur_s) * D'(cur_v);
        over_l = acc_l > S'(MAXV);
        over_r = acc_r > S'(MAXV);
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            snap_s   <= '0;
            snap_v   <= '0;
            snap_p   <= '0;
            acc_l    <= '0;
            acc_r    <= '0;
            mix_l    <= '0;
            mix_r    <= '0;
            mix_busy <= 1'b0;
            clip     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            clip    <= 1'b0;
            overrun <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sample_strobe) begin
                        snap_s   <= ch_sample;
                        snap_v   <= ch_vol;
                        snap_p   <= ch_pan;
                        acc_l    <= '0;
                        acc_r    <= '0;
                        idx      <= '0;
                        mix_busy <= 1'b1;
                        state    <= MIX;
                    end
                end
                MIX: begin
                    overrun <= sample_strobe;
                    if (cur_p[PAN_L_BIT])
                        acc_l <= acc_l + S'(prod);
                    if (cur_p[PAN_R_BIT])
                        acc_r <= acc_r + S'(prod);
                    if (idx == LAST)
                        state <= LOAD;
                    else
                        idx <= idx + 1'b1;
                end
                LOAD: begin
                    overrun  <= sample_strobe;
                    mix_l    <= over_l ? MAXV : acc_l[D-1:0];
                    mix_r    <= over_r ? MAXV : acc_r[D-1:0];
                    clip     <= over_l | over_r;
                    mix_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    mix_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    logic dith_l;
    logic dith_r;

`ifdef WAVUNO_DAC_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n)
            lfsr <= LFSR_SEED;
        else
            lfsr <= lfsr_next(lfsr);
    end

    // Full scale must keep its guaranteed zero, so no dither there
    assign dith_l = lfsr[0] & (mix_l != MAXV);
    assign dith_r = lfsr[0] & (mix_r != MAXV);
`else
    assign dith_l = 1'b0;
    assign dith_r = 1'b0;
`endif

    wavuno_sd_mod #(.D(D)) u_sd_l (
        .clk28  (clk28),
        .rst_n  (rst_n),
        .mix    (mix_l),
        .dither (dith_l),
        .sd_out (audio_out_left)
    );

    wavuno_sd_mod #(.D(D)) u_sd_r (
        .clk28  (clk28),
        .rst_n  (rst_n),
        .mix    (mix_r),
        .dither (dith_r),
        .sd_out (audio_out_right)
    );

endmodule

// File: tb/tb_wavuno_stereo_dac.sv
// Directed bench for wavuno_stereo_dac (NCH=4, SW=8, D=12).
// Mix levels, latency, clip, overrun, reset and pulse density.
module tb_wavuno_stereo_dac;

    logic        clk28;
    logic        rst_n;
    logic        sample_strobe;
    logic [31:0] ch_sample;
    logic [15:0] ch_vol;
    logic [7:0]  ch_pan;
    logic        audio_out_left;
    logic        audio_out_right;
    logic        mix_busy;
    logic        clip;
    logic        overrun;

    int n_chk  = 0;
    int n_fail = 0;

    wavuno_stereo_dac #(.NCH(4), .SW(8)) dut (
        .clk28           (clk28),
        .rst_n           (rst_n),
        .sample_strobe   (sample_strobe),
        .ch_sample       (ch_sample),
        .ch_vol          (ch_vol),
        .ch_pan          (ch_pan),
        .audio_out_left  (audio_out_left),
        .audio_out_right (audio_out_right),
        .mix_busy        (mix_busy),
        .clip            (clip),
        .overrun         (overrun)
    );

    initial begin
        clk28 = 1'b0;
        forever #5 clk28 = ~clk28;
    end

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic outs_zero(input string tag);
        chk({tag, "_left"},  32'(audio_out_left),  0);
        chk({tag, "_right"}, 32'(audio_out_right), 0);
        chk({tag, "_busy"},  32'(mix_busy),        0);
        chk({tag, "_clip"},  32'(clip),            0);
        chk({tag, "_ovr"},   32'(overrun),         0);
    endtask

    // Strobe applied before edge 0; loop index c = edges seen since.
    task automatic frame(
        input string       tag,
        input logic [31:0] smp,
        input logic [15:0] vol,
        input logic [7:0]  pan,
        input int          dup_at,
        input logic [11:0] prev_l,
        input logic [11:0] prev_r,
        input logic [11:0] exp_l,
        input logic [11:0] exp_r,
        input int          exp_clip,
        input int          exp_ovr
    );
        int n_busy = 0;
        int n_clip = 0;
        int n_ovr  = 0;
        logic [11:0] l4 = '0;
        logic [11:0] r4 = '0;
        logic [11:0] l5 = '0;
        logic [11:0] r5 = '0;
        @(negedge clk28);
        ch_sample     = smp;
        ch_vol        = vol;
        ch_pan        = pan;
        sample_strobe = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk28);
            n_busy += int'(mix_busy);
            n_clip += int'(clip);
            n_ovr  += int'(overrun);
            if (c == 4) begin
                l4 = dut.mix_l;
                r4 = dut.mix_r;
            end
            if (c == 5) begin
                l5 = dut.mix_l;
                r5 = dut.mix_r;
            end
            sample_strobe = (c == dup_at);
            ch_sample     = $urandom;
            ch_vol        = 16'($urandom);
            ch_pan        = 8'($urandom);
        end
        chk({tag, "_busy_cycles"}, n_busy, 5);
        chk({tag, "_clip_cnt"},    n_clip, exp_clip);
        chk({tag, "_ovr_cnt"},     n_ovr,  exp_ovr);
        chk({tag, "_l_before"},    32'(l4), 32'(prev_l));
        chk({tag, "_r_before"},    32'(r4), 32'(prev_r));
        chk({tag, "_l_mix"},       32'(l5), 32'(exp_l));
        chk({tag, "_r_mix"},       32'(r5), 32'(exp_r));
    endtask

    task automatic density(
        input string tag,
        input int    exp_l,
        input int    exp_r
    );
        int nl = 0;
        int nr = 0;
        repeat (8) @(negedge clk28);
        repeat (4096) begin
            @(negedge clk28);
            nl += int'(audio_out_left);
            nr += int'(audio_out_right);
        end
        chk({tag, "_ones_l"}, nl, exp_l);
        chk({tag, "_ones_r"}, nr, exp_r);
    endtask

    initial begin
        rst_n         = 1'b0;
        sample_strobe = 1'b0;
        ch_sample     = 32'h5A5A_A5A5;
        ch_vol        = 16'hFFFF;
        ch_pan        = 8'hFF;

        repeat (4) @(negedge clk28);
        outs_zero("rst_hold");
        chk("rst_mix_l", 32'(dut.mix_l), 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk28);
            outs_zero("rst_release");
        end

        // ch0 0x80 * 15 = 0x780; other channels muted
        frame("mono", 32'h55AA_3380, 16'hFFFF, 8'h03, -1,
              12'h000, 12'h000, 12'h780, 12'h780, 0, 0);
        density("mono", 1920, 1920);

        // ch1 0xFF * 15 = 0xEF1, left only
        frame("panl", 32'h1234_FF56, 16'h00F0, 8'h04, -1,
              12'h780, 12'h780, 12'hEF1, 12'h000, 0, 0);
        density("panl", 3825, 0);

        // 4 * 3825 = 15300 saturates to 0xFFF on both sides
        frame("sat", 32'hFFFF_FFFF, 16'hFFFF, 8'hFF, -1,
              12'hEF1, 12'h000, 12'hFFF, 12'hFFF, 1, 0);
        density("sat", 4095, 4095);

        // L: 0x10*3 + 1*1 = 49, R: 0x20*2 + 1*1 = 65
        frame("ovr", 32'h0120_0010, 16'h1203, 8'hE1, 1,
              12'hFFF, 12'hFFF, 12'h031, 12'h041, 0, 1);

        @(negedge clk28);
        ch_sample     = 32'h0000_0080;
        ch_vol        = 16'h000F;
        ch_pan        = 8'h03;
        sample_strobe = 1'b1;
        @(negedge clk28);
        sample_strobe = 1'b0;
        @(negedge clk28);
        rst_n = 1'b0;
        #1;
        outs_zero("midmix_rst");
        chk("midmix_mix_l", 32'(dut.mix_l), 0);
        chk("midmix_mix_r", 32'(dut.mix_r), 0);
        repeat (2) @(negedge clk28);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk28);
            outs_zero("midmix_release");
        end
        chk("midmix_idle_l", 32'(dut.mix_l), 0);

        frame("remix", 32'h0000_0080, 16'h000F, 8'h03, -1,
              12'h000, 12'h000, 12'h780, 12'h780, 0, 0);
        density("remix", 1920, 1920);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
